fifo_ctrl: RTL

//  Pointer/flag controller for the RAM_memory-based FIFO. Turns push/pop requests

---
 rtl/fifo_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a RAM-backed FIFO.
// Converts push/pop requests into RAM write/read enables and addresses.
// Tracks occupancy, builds the status flags and keeps sticky overflow/underflow errors.
// An INIT/IDLE/ACTIVE/ERROR state machine sequences everything.
module fifo_ctrl #(
    parameter int DATA_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [DATA_SIZE:0]   afull_thr,
    input  logic [DATA_SIZE:0]   aempty_thr,
    input  logic                 push,
    input  logic                 pop,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [DATA_SIZE-1:0] wr_ptr,
    output logic [DATA_SIZE-1:0] rd_ptr,
    output logic [DATA_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow_err,
    output logic                 underflow_err,
    output logic                 valid_out,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [DATA_SIZE:0] DEPTH_C     = {1'b1, {DATA_SIZE{1'b0}}};
    localparam logic [DATA_SIZE:0] ONE_C       = {{DATA_SIZE{1'b0}}, 1'b1};
    localparam logic [DATA_SIZE:0] AFULL_RST_C = DEPTH_C - ONE_C;

    state_t                 state_r;
    logic [DATA_SIZE-1:0]   wr_ptr_r, rd_ptr_r;
    logic [DATA_SIZE:0]     count_r;
    logic [DATA_SIZE:0]     afull_thr_r, aempty_thr_r;
    logic                   full_r, empty_r, afull_r, aempty_r;
    logic                   ovf_r, unf_r, valid_r;

    logic                   xfer_s, wr_en_s, rd_en_s, ovf_s, unf_s;
    logic [DATA_SIZE:0]     count_next_s, afthr_sel_s, aethr_sel_s;

    // Transfer enables, error detection and next occupancy for the current cycle
    always_comb begin
        xfer_s       = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        ovf_s        = 1'b0;
        unf_s        = 1'b0;
        count_next_s = count_r;
        afthr_sel_s  = afull_thr_r;
        aethr_sel_s  = aempty_thr_r;
        if ((state_r == ST_IDLE || state_r == ST_ACTIVE) && !init) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
        // A pop alongside a push to a full FIFO frees the slot being written
        wr_en_s = xfer_s & push & (~full_r | pop);
        rd_en_s = xfer_s & pop & ~empty_r;
        ovf_s   = xfer_s & push & ~wr_en_s;
        unf_s   = xfer_s & pop & empty_r;
        if (state_r == ST_INIT) begin
            // Flags leaving INIT must reflect the thresholds being latched now
            count_next_s = {(DATA_SIZE+1){1'b0}};
            afthr_sel_s  = afull_thr;
            aethr_sel_s  = aempty_thr;
        end else begin
            count_next_s = count_r + (DATA_SIZE+1)'(wr_en_s) - (DATA_SIZE+1)'(rd_en_s);
        end
    end

    // State machine, pointers, occupancy, thresholds and registered status flags
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r      <= ST_INIT;
            wr_ptr_r     <= {DATA_SIZE{1'b0}};
            rd_ptr_r     <= {DATA_SIZE{1'b0}};
            count_r      <= {(DATA_SIZE+1){1'b0}};
            afull_thr_r  <= AFULL_RST_C;
            aempty_thr_r <= ONE_C;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            afull_r      <= 1'b0;
            aempty_r     <= 1'b1;
            ovf_r        <= 1'b0;
            unf_r        <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    wr_ptr_r     <= {DATA_SIZE{1'b0}};
                    rd_ptr_r     <= {DATA_SIZE{1'b0}};
                    ovf_r        <= 1'b0;
                    unf_r        <= 1'b0;
                    afull_thr_r  <= afull_thr;
                    aempty_thr_r <= aempty_thr;
                    state_r      <= init ? ST_INIT : ST_IDLE;
                end
                ST_IDLE, ST_ACTIVE: begin
                    wr_ptr_r <= wr_ptr_r + DATA_SIZE'(wr_en_s);
                    rd_ptr_r <= rd_ptr_r + DATA_SIZE'(rd_en_s);
                    ovf_r    <= ovf_r | ovf_s;
                    unf_r    <= unf_r | unf_s;
                    if (init) begin
                        state_r <= ST_INIT;
                    end else if (ovf_s || unf_s) begin
                        state_r <= ST_ERROR;
                    end else if (count_next_s != {(DATA_SIZE+1){1'b0}}) begin
                        state_r <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state_r <= init ? ST_INIT : ST_ERROR;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_C);
            empty_r  <= (count_next_s == {(DATA_SIZE+1){1'b0}});
            afull_r  <= (count_next_s >= afthr_sel_s);
            aempty_r <= (count_next_s <= aethr_sel_s);
            valid_r  <= rd_en_s;
        end
    end

    assign wr_en         = wr_en_s;
    assign rd_en         = rd_en_s;
    assign wr_ptr        = wr_ptr_r;
    assign rd_ptr        = rd_ptr_r;
    assign count         = count_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign almost_full   = afull_r;
    assign almost_empty  = aempty_r;
    assign overflow_err  = ovf_r;
    assign underflow_err = unf_r;
    assign valid_out     = valid_r;
    assign state         = state_r;

endmodule
